data_mem_param: RTL and testbench
=================================

DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Derived constant BE_W = DATA_W/8, the number of byte lanes.
REQ-004 clk  input  1  single clock, all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 MEM_memread  input  1  read request.
REQ-007 MEM_memwrite  input  1  write request.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 wstrb  input  BE_W  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 clr_req  input  1  request for a full memory zero-fill.
REQ-012 rdata  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  one-cycle pulse marking new rdata.
REQ-014 busy  output  1  zero-fill in progress; accesses not accepted.
REQ-015 err  output  1  one-cycle pulse marking a rejected request.

Function
REQ-016 The FSM SHALL have exactly three states: INIT (zero-fill), IDLE, and DONE (one-cycle fill completion).
REQ-017 In INIT, each cycle SHALL write 0 to memory[cnt] and increment the ADDR_W-bit counter cnt, with busy=1.
REQ-018 In INIT, when cnt==DEPTH-1, the write SHALL complete and the FSM SHALL move to DONE, so the fill takes exactly DEPTH cycles.
REQ-019 DONE SHALL last one cycle with busy=0 and go to IDLE; accesses in DONE SHALL be serviced as in IDLE.
REQ-020 In IDLE, clr_req=1 SHALL reset cnt to 0 and enter INIT; a read or write in the same cycle SHALL be rejected.
REQ-021 In IDLE, MEM_memread=1 SHALL load rdata<=memory[addr] at the next edge and pulse rvalid=1 for one cycle (read latency 1).
REQ-022 In IDLE, MEM_memwrite=1 with MEM_memread=0 SHALL update only lanes with wstrb[i]=1; other lanes SHALL be retained.
REQ-023 A write with wstrb=0 SHALL be a no-op and SHALL NOT raise err.
REQ-024 When MEM_memread and MEM_memwrite are both 1, the read SHALL be performed, the write SHALL be dropped, and err SHALL pulse in the same cycle as rvalid.
REQ-025 A read or write request while busy=1 SHALL be ignored and SHALL pulse err one cycle later; rvalid SHALL stay 0.
REQ-026 clr_req while busy=1 SHALL be ignored and the fill SHALL NOT restart.
REQ-027 rdata SHALL hold its last value when no read completes.
REQ-028 rdata SHALL never be cleared by a zero-fill; only reset or a read SHALL change it.
REQ-029 A read of an address written in the previous cycle SHALL return the new data, because the memory updates at the write edge.
REQ-030 addr is always in range; no wrap or bounds logic is required.

Reset
REQ-031 reset_n=0 SHALL immediately force: state=INIT, cnt=0, rdata=0, rvalid=0, err=0, busy=1.
REQ-032 Memory contents SHALL NOT be cleared asynchronously; zeroing happens only by the INIT fill after reset_n rises.
REQ-033 Reset asserted mid-fill or mid-access SHALL abort the operation, and the fill SHALL restart from address 0 after release.

Verification
REQ-034 Release reset, defaults, count cycles -> busy=1 for exactly 256 cycles, then 0; read of any address returns 0x00000000 with rvalid one cycle after the request.
REQ-035 Write addr 0x10, wdata=0xAABBCCDD, wstrb=4'b1111, then wstrb=4'b0101 with wdata=0x11223344 -> read 0x10 gives 0xAA22CC44.
REQ-036 Assert read and write together at addr 0x20 holding 0x5 -> rdata=0x5, rvalid=1 and err=1 in the same cycle; memory[0x20] unchanged.
REQ-037 Write 0x7 to addr 3, pulse clr_req, and read during busy -> err pulses, no rvalid; after 256 busy cycles, read addr 3 returns 0.
REQ-038 Pull reset_n low at fill cycle 100, release -> busy restarts and lasts a full 256 cycles; rdata=0.
REQ-039 Parameter sweep DATA_W=16, ADDR_W=4 -> fill lasts 16 cycles; 2-lane byte-write checks pass.

Source files
------------

// File: rtl/data_mem_param.sv
// Byte-lane-writable single-port data memory with registered reads and a
// self-clearing zero-fill sequencer that runs after reset or on request.
module data_mem_param #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 8,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              MEM_memread,
   input  logic              MEM_memwrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   wstrb,
   input  logic              clr_req,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              fill_we, rd_en, wr_en, err_d;
   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_we = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         INIT: begin
            // Fill writes are held off while reset is asserted so memory is only zeroed after release.
            fill_we = reset_n;
            cnt_d   = cnt_q + ADDR_W'(1);
            err_d   = MEM_memread | MEM_memwrite;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (clr_req) begin
               cnt_d   = '0;
               state_d = INIT;
               err_d   = MEM_memread | MEM_memwrite;
            end else begin
               rd_en = MEM_memread;
               wr_en = MEM_memwrite & ~MEM_memread;
               err_d = MEM_memread & MEM_memwrite;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // NOTE: the array has no reset branch; clearing it is the job of the INIT fill, not the reset net.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
         rdata   <= '0;
         rvalid  <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rvalid  <= rd_en;
         err     <= err_d;
         if (rd_en) rdata <= mem[addr];
      end
   end

   assign busy = (state_q == INIT);

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param: default 32x256 instance plus a 16x16
// instance for the narrow-parameter byte-lane checks.
module tb_data_mem_param;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rd, wr, clr;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        rvalid, busy, err;

   logic        s_rst_n;
   logic        s_rd, s_wr, s_clr;
   logic [3:0]  s_addr;
   logic [15:0] s_wdata;
   logic [1:0]  s_wstrb;
   logic [15:0] s_rdata;
   logic        s_rvalid, s_busy, s_err;

   int n_tests = 0;
   int n_fail  = 0;
   int n;

   always #5 clk = ~clk;

   data_mem_param dut (
      .clk(clk), .reset_n(reset_n), .MEM_memread(rd), .MEM_memwrite(wr),
      .addr(addr), .wdata(wdata), .wstrb(wstrb), .clr_req(clr),
      .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
   );

   data_mem_param #(.DATA_W(16), .ADDR_W(4)) dut_s (
      .clk(clk), .reset_n(s_rst_n), .MEM_memread(s_rd), .MEM_memwrite(s_wr),
      .addr(s_addr), .wdata(s_wdata), .wstrb(s_wstrb), .clr_req(s_clr),
      .rdata(s_rdata), .rvalid(s_rvalid), .busy(s_busy), .err(s_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      wr = 1'b1; addr = a; wdata = d; wstrb = s;
      step();
      wr = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a);
      rd = 1'b1; addr = a;
      step();
      rd = 1'b0;
   endtask

   task automatic wait_fill(output int cycles);
      cycles = 0;
      while (busy && cycles < 1000) begin
         step();
         cycles++;
      end
   endtask

   task automatic s_wait_fill(output int cycles);
      cycles = 0;
      while (s_busy && cycles < 1000) begin
         step();
         cycles++;
      end
   endtask

   task automatic s_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
      s_wr = 1'b1; s_addr = a; s_wdata = d; s_wstrb = s;
      step();
      s_wr = 1'b0;
   endtask

   task automatic s_read(input logic [3:0] a);
      s_rd = 1'b1; s_addr = a;
      step();
      s_rd = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rd = 1'b0; wr = 1'b0; clr = 1'b0;
      addr = '0; wdata = '0; wstrb = '0;
      s_rst_n = 1'b0; s_rd = 1'b0; s_wr = 1'b0; s_clr = 1'b0;
      s_addr = '0; s_wdata = '0; s_wstrb = '0;

      #3;
      check("rst_busy",   32'(busy),   32'd1);
      check("rst_rdata",  rdata,       32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_err",    32'(err),    32'd0);

      step(); step();
      reset_n = 1'b1;
      wait_fill(n);
      check("fill_len", n, 256);
      check("fill_done_busy", 32'(busy), 32'd0);

      do_read(8'h55);
      check("init_rd_valid", 32'(rvalid), 32'd1);
      check("init_rd_data",  rdata,       32'h0000_0000);
      step();
      check("rvalid_pulse", 32'(rvalid), 32'd0);

      // Byte-lane merge
      do_write(8'h10, 32'hAABB_CCDD, 4'b1111);
      do_write(8'h10, 32'h1122_3344, 4'b0101);
      check("wr_no_err", 32'(err), 32'd0);
      do_read(8'h10);
      check("lane_rdata",  rdata,       32'hAA22_CC44);
      check("lane_rvalid", 32'(rvalid), 32'd1);
      step();
      check("rdata_hold", rdata, 32'hAA22_CC44);

      do_write(8'h10, 32'hFFFF_FFFF, 4'b0000);
      check("strb0_no_err", 32'(err), 32'd0);
      do_read(8'h10);
      check("strb0_noop", rdata, 32'hAA22_CC44);

      do_write(8'h30, 32'hCAFE_F00D, 4'b1111);
      do_read(8'h30);
      check("raw_next_cycle", rdata, 32'hCAFE_F00D);

      // Simultaneous read and write: read wins, write dropped, err with rvalid
      do_write(8'h20, 32'h0000_0005, 4'b1111);
      rd = 1'b1; wr = 1'b1; addr = 8'h20; wdata = 32'hDEAD_BEEF; wstrb = 4'b1111;
      step();
      rd = 1'b0; wr = 1'b0;
      check("rw_rdata",  rdata,       32'h5);
      check("rw_rvalid", 32'(rvalid), 32'd1);
      check("rw_err",    32'(err),    32'd1);
      do_read(8'h20);
      check("rw_mem_kept", rdata,     32'h5);
      check("rw_err_gone", 32'(err),  32'd0);

      // Clear request with a same-cycle read, then accesses while busy
      do_write(8'h03, 32'h0000_0007, 4'b1111);
      clr = 1'b1; rd = 1'b1; addr = 8'h03;
      step();
      clr = 1'b0;
      check("clr_busy",   32'(busy),   32'd1);
      check("clr_rd_err", 32'(err),    32'd1);
      check("clr_rd_rv",  32'(rvalid), 32'd0);
      step();
      rd = 1'b0;
      check("busy_rd_err", 32'(err),    32'd1);
      check("busy_rd_rv",  32'(rvalid), 32'd0);
      step();
      check("busy_err_pulse", 32'(err), 32'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      wait_fill(n);
      check("clr_no_restart", n, 253);
      check("fill_keeps_rdata", rdata, 32'h5);
      do_read(8'h03);
      check("clr_zeroed", rdata, 32'd0);

      // Reset in the middle of a fill
      do_write(8'h10, 32'h1234_5678, 4'b1111);
      do_read(8'h10);
      check("pre_rst_rdata", rdata, 32'h1234_5678);
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (100) step();
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy), 32'd1);
      check("mid_rst_rdata", rdata,     32'd0);
      step();
      reset_n = 1'b1;
      wait_fill(n);
      check("refill_len", n, 256);
      check("refill_rdata", rdata, 32'd0);

      // Narrow instance: 16-bit data, 16 words
      check("s_rst_busy", 32'(s_busy), 32'd1);
      s_rst_n = 1'b1;
      s_wait_fill(n);
      check("s_fill_len", n, 16);
      s_write(4'h5, 16'hBEEF, 2'b11);
      s_write(4'h5, 16'h1234, 2'b10);
      s_read(4'h5);
      check("s_lane_hi",  32'(s_rdata),  32'h12EF);
      check("s_rvalid",   32'(s_rvalid), 32'd1);
      s_write(4'h5, 16'h0055, 2'b01);
      s_read(4'h5);
      check("s_lane_lo",  32'(s_rdata),  32'h1255);
      s_read(4'h9);
      check("s_fill_zero", 32'(s_rdata), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
